bus_dma_arbiter: RTL and testbench

BUS_DMA_ARBITER -- requirements
Module: bus_dma_arbiter

---
 rtl/bus_dma_arbiter_if.sv | 24 ++
 rtl/bus_dma_arbiter.sv | 85 ++++++++
 tb/tb_bus_dma_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_dma_arbiter_if.sv
// CPU-side and memory-bus-side signals of the DMA arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface bus_dma_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_odata;
  logic        cpu_rw;
  logic [7:0]  cpu_idata;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rw;
  logic [7:0]  bus_rdata;
  logic        dma_busy;

  modport slave (
    input  cpu_addr, cpu_odata, cpu_rw, bus_rdata,
    output cpu_idata, cpu_rdy, bus_addr, bus_wdata, bus_rw, dma_busy
  );

  modport master (
    output cpu_addr, cpu_odata, cpu_rw, bus_rdata,
    input  cpu_idata, cpu_rdy, bus_addr, bus_wdata, bus_rw, dma_busy
  );
endinterface

// File: rtl/bus_dma_arbiter.sv
// Sprite-style DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies the
// 256 bytes of the selected page, one READ/WRITE pair per byte, to DEST_ADDR.
module bus_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_dma_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALT  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q,  page_d;
  logic [7:0] idx_q,   idx_d;
  logic [7:0] data_q,  data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    page_d        = page_q;
    idx_d         = idx_q;
    data_d        = data_q;
    bus.bus_addr  = bus.cpu_addr;
    bus.bus_wdata = bus.cpu_odata;
    bus.bus_rw    = bus.cpu_rw;
    bus.cpu_rdy   = 1'b1;
    bus.dma_busy  = 1'b1;
    bus.cpu_idata = bus.bus_rdata;

    unique case (state_q)
      IDLE: begin
        bus.dma_busy = 1'b0;
        // The trigger write itself still reaches the bus unchanged.
        if (!bus.cpu_rw && bus.cpu_addr == DMA_REG_ADDR) begin
          page_d  = bus.cpu_odata;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        // Wait for the CPU to finish its write burst before stealing the bus.
        bus.cpu_rdy = 1'b0;
        if (bus.cpu_rw) state_d = READ;
      end
      READ: begin
        bus.cpu_rdy   = 1'b0;
        bus.bus_addr  = {page_q, idx_q};
        bus.bus_wdata = data_q;
        bus.bus_rw    = 1'b1;
        data_d        = bus.bus_rdata;
        state_d       = WRITE;
      end
      WRITE: begin
        bus.cpu_rdy   = 1'b0;
        bus.bus_addr  = DEST_ADDR;
        bus.bus_wdata = data_q;
        bus.bus_rw    = 1'b0;
        idx_d         = idx_q + 8'd1;
        state_d       = (idx_q == 8'hFF) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Randomized bench for bus_dma_arbiter: each transfer is checked cycle by
// cycle against the expected bus schedule derived from page, halt length and a memory image.
module tb_bus_dma_arbiter;
  localparam logic [15:0] DMA  = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] seed = 8'h00;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  bus_dma_arbiter_if dif();

  // Memory image: each address returns a byte derived from the address and seed.
  assign dif.bus_rdata = (dif.bus_addr[7:0] * 8'd7) ^ dif.bus_addr[15:8] ^ seed;

  bus_dma_arbiter #(.DMA_REG_ADDR(DMA), .DEST_ADDR(DEST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a, input logic [7:0] s);
    logic [7:0] lo;
    lo = a[7:0] * 8'd7;
    return lo ^ a[15:8] ^ s;
  endfunction

  task automatic cpu_random(input bit allow_trigger);
    dif.cpu_addr  = 16'($urandom);
    dif.cpu_odata = 8'($urandom);
    dif.cpu_rw    = 1'($urandom);
    if (!allow_trigger && !dif.cpu_rw && dif.cpu_addr == DMA) dif.cpu_addr = DMA + 16'd1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_random(1'b1);
      #1;
      tests_run++;
      if ({dif.bus_addr, dif.bus_wdata, dif.bus_rw, dif.cpu_rdy, dif.dma_busy, dif.cpu_idata} !==
          {dif.cpu_addr, dif.cpu_odata, dif.cpu_rw, 1'b1, 1'b0, dif.bus_rdata}) begin
        tests_failed++;
        $display("[TB] FAIL reset_state: addr %h rw %b rdy %b busy %b, required addr %h rw %b rdy 1 busy 0",
                 dif.bus_addr, dif.bus_rw, dif.cpu_rdy, dif.dma_busy, dif.cpu_addr, dif.cpu_rw);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset: released");
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    dif.cpu_addr = 16'h0099; dif.cpu_odata = 8'hFF; dif.cpu_rw = 1'b0;
    #1;
    tests_run++;
    if ({dif.bus_addr, dif.bus_wdata, dif.bus_rw, dif.cpu_rdy} !== {16'h0099, 8'hFF, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL sta_99: addr %h wdata %h rw %b rdy %b, required 0099 ff 0 1",
               dif.bus_addr, dif.bus_wdata, dif.bus_rw, dif.cpu_rdy);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cpu_random(1'b0);
      #1;
      tests_run++;
      if ({dif.bus_addr, dif.bus_wdata, dif.bus_rw, dif.cpu_rdy, dif.dma_busy, dif.cpu_idata} !==
          {dif.cpu_addr, dif.cpu_odata, dif.cpu_rw, 1'b1, 1'b0, dif.bus_rdata}) begin
        tests_failed++;
        $display("[TB] FAIL idle_pass: addr %h rw %b rdy %b busy %b, required addr %h rw %b rdy 1 busy 0",
                 dif.bus_addr, dif.bus_rw, dif.cpu_rdy, dif.dma_busy, dif.cpu_addr, dif.cpu_rw);
      end
    end
    $display("[TB] passthrough: STA $99 and 8 random idle cycles");
  endtask

  task automatic run_transfer(input string name, input logic [7:0] page, input int halt_extra);
    int          h, total, errs, first_k, j;
    logic [15:0] exp_addr, bad_got, bad_exp, last_read;
    logic [7:0]  exp_wd, n;
    logic        exp_rw;
    bit          chk_wd, zero_hit;
    h = halt_extra + 1;
    total = h + 512;
    errs = 0; first_k = -1; zero_hit = 0; last_read = 16'h0000;
    bad_got = 16'h0000; bad_exp = 16'h0000;
    seed = 8'($urandom);

    @(negedge clk);
    dif.cpu_addr = DMA; dif.cpu_odata = page; dif.cpu_rw = 1'b0;
    #1;
    tests_run++;
    if ({dif.bus_addr, dif.bus_wdata, dif.bus_rw, dif.cpu_rdy, dif.dma_busy} !==
        {DMA, page, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL %s_trigger: addr %h wdata %h rw %b rdy %b busy %b, required %h %h 0 1 0",
               name, dif.bus_addr, dif.bus_wdata, dif.bus_rw, dif.cpu_rdy, dif.dma_busy, DMA, page);
    end

    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      cpu_random(1'b1);
      if (k <= halt_extra) begin
        dif.cpu_rw = 1'b0;
        if (k == 1) begin dif.cpu_addr = DMA; dif.cpu_odata = ~page; end
      end else if (k == h) begin
        dif.cpu_rw = 1'b1;
      end else if (k == h + 21) begin
        dif.cpu_addr = DMA; dif.cpu_rw = 1'b0; dif.cpu_odata = ~page;
      end
      #1;
      chk_wd = 1'b1;
      if (k <= h) begin
        exp_addr = dif.cpu_addr; exp_wd = dif.cpu_odata; exp_rw = dif.cpu_rw;
      end else begin
        j = k - h - 1;
        n = 8'(j / 2);
        if (j % 2 == 0) begin
          exp_addr = {page, n}; exp_wd = 8'h00; exp_rw = 1'b1; chk_wd = 1'b0;
          last_read = dif.bus_addr;
        end else begin
          exp_addr = DEST; exp_wd = mem_byte({page, n}, seed); exp_rw = 1'b0;
        end
        if (dif.bus_addr == 16'h0000) zero_hit = 1'b1;
      end
      if (dif.bus_addr !== exp_addr || (chk_wd && dif.bus_wdata !== exp_wd) ||
          dif.bus_rw !== exp_rw || dif.cpu_rdy !== 1'b0 || dif.dma_busy !== 1'b1 ||
          dif.cpu_idata !== dif.bus_rdata) begin
        errs++;
        if (first_k < 0) begin first_k = k; bad_got = dif.bus_addr; bad_exp = exp_addr; end
      end
    end
    tests_run++;
    if (errs !== 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_trace: %0d bad cycles, first at cycle %0d addr %h, required addr %h",
               name, errs, first_k, bad_got, bad_exp);
    end

    @(negedge clk);
    cpu_random(1'b0);
    #1;
    tests_run++;
    if ({dif.bus_addr, dif.bus_rw, dif.cpu_rdy, dif.dma_busy} !== {dif.cpu_addr, dif.cpu_rw, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL %s_done: cycle %0d addr %h rdy %b busy %b, required addr %h rdy 1 busy 0",
               name, total + 1, dif.bus_addr, dif.cpu_rdy, dif.dma_busy, dif.cpu_addr);
    end

    if (page == 8'hFF) begin
      tests_run++;
      if (last_read !== 16'hFFFF) begin
        tests_failed++;
        $display("[TB] FAIL %s_last_read: got %h, required ffff", name, last_read);
      end
      tests_run++;
      if (zero_hit) begin
        tests_failed++;
        $display("[TB] FAIL %s_no_wrap: saw address 0000, required none", name);
      end
    end
    $display("[TB] %s: page %h, %0d halt cycles, %0d cycles to ready", name, page, h, total + 1 - 1);
  endtask

  task automatic test_basic();          run_transfer("basic", 8'h02, 0); endtask
  task automatic test_halt_stretch();   run_transfer("halt_stretch", 8'($urandom), 3); endtask
  task automatic test_page_wrap();      run_transfer("page_wrap", 8'hFF, 0); endtask
  task automatic test_back_to_back();
    run_transfer("b2b_a", 8'($urandom), int'($urandom_range(0, 4)));
    run_transfer("b2b_b", 8'($urandom), int'($urandom_range(0, 4)));
  endtask

  task automatic test_reset_mid();
    logic [7:0] page;
    int         bad;
    page = 8'($urandom);
    @(negedge clk);
    dif.cpu_addr = DMA; dif.cpu_odata = page; dif.cpu_rw = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      cpu_random(1'b0);
      dif.cpu_rw = 1'b1;
    end
    #1;
    tests_run++;
    if ({dif.bus_addr, dif.bus_rw} !== {page, 8'h40, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL mid_read_40: addr %h rw %b, required %h 1", dif.bus_addr, dif.bus_rw, {page, 8'h40});
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({dif.bus_addr, dif.bus_wdata, dif.bus_rw, dif.cpu_rdy, dif.dma_busy} !==
        {dif.cpu_addr, dif.cpu_odata, dif.cpu_rw, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: addr %h rdy %b busy %b, required addr %h rdy 1 busy 0",
               dif.bus_addr, dif.cpu_rdy, dif.dma_busy, dif.cpu_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      cpu_random(1'b0);
      dif.cpu_rw = 1'b1;
      #1;
      if (dif.bus_rw !== 1'b1 || dif.cpu_rdy !== 1'b1 || dif.dma_busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL after_abort: %0d DMA-active cycles, required 0", bad);
    end
    $display("[TB] reset_mid: page %h aborted at idx 40", page);
  endtask

  initial begin
    dif.cpu_addr = 16'h0000; dif.cpu_odata = 8'h00; dif.cpu_rw = 1'b1;
    test_reset();
    test_passthrough();
    test_basic();
    test_halt_stretch();
    test_page_wrap();
    test_reset_mid();
    run_transfer("post_abort", 8'($urandom), 1);
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
